// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the bit-counter width helper.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Number of bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_fsm.sv
// Bit-serial WIDTH-bit adder, LSB first, with start/busy/done handshake.
// Define SERIAL_ADDSUB_SUB_EN to add the sub port (a - b - cin, cout = borrow).
module serial_addsub_fsm
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDSUB_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = clog2(WIDTH + 1);

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   a_sh_reg, a_sh_next;
   logic [WIDTH-1:0]   b_sh_reg, b_sh_next;
   logic [WIDTH-1:0]   sum_reg, sum_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               carry_reg, carry_next;
   logic               cout_reg, cout_next;
   logic               sub_reg, sub_next;
   logic               sub_in;
   logic               fa_s, fa_co;

`ifdef SERIAL_ADDSUB_SUB_EN
   assign sub_in = sub;
`else
   assign sub_in = 1'b0;
`endif

   full_adder_cell u_fa (
      .a  (a_sh_reg[0]),
      .b  (b_sh_reg[0]),
      .ci (carry_reg),
      .s  (fa_s),
      .co (fa_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         a_sh_reg  <= '0;
         b_sh_reg  <= '0;
         sum_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         sub_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_sh_reg  <= a_sh_next;
         b_sh_reg  <= b_sh_next;
         sum_reg   <= sum_next;
         cnt_reg   <= cnt_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
         sub_reg   <= sub_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_sh_next  = a_sh_reg;
      b_sh_next  = b_sh_reg;
      sum_next   = sum_reg;
      cnt_next   = cnt_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      sub_next   = sub_reg;
      busy       = (state_reg != ST_IDLE);
      done       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + ~cin, so invert b and the initial carry.
               a_sh_next  = a;
               b_sh_next  = b ^ {WIDTH{sub_in}};
               carry_next = cin ^ sub_in;
               sub_next   = sub_in;
               cnt_next   = '0;
               sum_next   = '0;
               cout_next  = 1'b0;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_next   = {fa_s, sum_reg[WIDTH-1:1]};
            a_sh_next  = a_sh_reg >> 1;
            b_sh_next  = b_sh_reg >> 1;
            carry_next = fa_co;
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(WIDTH - 1)) begin
               cout_next  = fa_co ^ sub_reg;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule

// File: tb/tb_serial_addsub_fsm.sv
// Self-checking bench for serial_addsub_fsm (WIDTH=8): directed cases plus
// randomized operations checked against an arithmetic reference model.
module tb_serial_addsub_fsm;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks;
   int errors;

   serial_addsub_fsm #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDSUB_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: {cout,sum} of the whole operation from plain integer arithmetic.
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                            input logic mc, input logic ms);
      int diff;
      int total;
      logic [WIDTH:0] r;
      if (ms) begin
         diff  = int'(ma) - int'(mb) - int'(mc);
         r[WIDTH-1:0] = diff[WIDTH-1:0];
         r[WIDTH]     = (int'(ma) < int'(mb) + int'(mc));
      end else begin
         total = int'(ma) + int'(mb) + int'(mc);
         r     = total[WIDTH:0];
      end
      return r;
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input logic ts, input bit noise);
      int lat;
      logic [WIDTH:0] exp;
      exp = model(ta, tb, tc, ts);
      @(negedge clk);
      a = ta; b = tb; cin = tc; sub = ts; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      // Operands change after capture; must not affect the result.
      a = ~ta; b = WIDTH'($urandom); cin = ~tc; sub = ~ts;
      check("busy_run", 32'(busy), 32'd1);
      while (!done && lat < 20) begin
         start = (noise && lat == 3) ? 1'b1 : 1'b0;
         @(negedge clk);
         lat = lat + 1;
      end
      start = 1'b0;
      check("latency", 32'(lat), 32'(WIDTH + 1));
      check("sum", 32'(sum), 32'(exp[WIDTH-1:0]));
      check("cout", 32'(cout), 32'(exp[WIDTH]));
      check("busy_done", 32'(busy), 32'd1);
      $display("op a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b (exp %h/%b) lat=%0d",
               ta, tb, tc, ts, sum, cout, exp[WIDTH-1:0], exp[WIDTH], lat);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("sum_hold", 32'(sum), 32'(exp[WIDTH-1:0]));
      check("cout_hold", 32'(cout), 32'(exp[WIDTH]));
   endtask

   initial begin
      int t;
      int t1;
      logic rs;
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

      // Reset held three cycles.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      $display("reset released: busy=%b done=%b sum=%h cout=%b", busy, done, sum, cout);

      run_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("partial_sum", 32'(sum), 32'h0000_00F0);
      #1 rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_sum", 32'(sum), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      $display("reset mid-run: busy=%b sum=%h", busy, sum);
      @(negedge clk);
      rst = 1'b0;
      run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);

      // Start held high: back-to-back operations.
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
      t = 0;
      @(negedge clk); t = t + 1;
      while (!done && t < 40) begin
         @(negedge clk); t = t + 1;
      end
      t1 = t;
      check("b2b_lat", 32'(t1), 32'(WIDTH + 1));
      check("b2b_sum0", 32'(sum), 32'h02);
      check("b2b_cout0", 32'(cout), 32'd0);
      $display("b2b op0 01+01 -> sum=%h cout=%b at cycle %0d", sum, cout, t1);
      a = 8'h80; b = 8'h80;
      @(negedge clk); t = t + 1;
      while (!done && t < 60) begin
         @(negedge clk); t = t + 1;
      end
      start = 1'b0;
      check("b2b_spacing", 32'(t - t1), 32'(WIDTH + 2));
      check("b2b_sum1", 32'(sum), 32'h00);
      check("b2b_cout1", 32'(cout), 32'd1);
      $display("b2b op1 80+80 -> sum=%h cout=%b spacing=%0d", sum, cout, t - t1);
      @(negedge clk);

`ifdef SERIAL_ADDSUB_SUB_EN
      run_op(8'h05, 8'h07, 1'b0, 1'b1, 1'b0);
      run_op(8'h20, 8'h01, 1'b1, 1'b1, 1'b0);
`endif

      // Randomized operations, with occasional ignored start pulses.
      for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADDSUB_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), rs,
                ($urandom_range(0, 1) == 1));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
